regbank_op_seq: RTL
===================

# regbank_op_seq

Register-file client sequencer. It accepts one register-to-register operation per handshake, reads both source operands through the regbank read ports, computes a 32-bit ALU result, and writes it back through the regbank write port. It is the requester side of the 32x32 register file interface: it drives `sr1`, `sr2`, `dr`, `write` and `wrData`, and consumes `rdData1` and `rdData2`.

## Interface
Parameters:
- None. Widths are fixed: 32-bit data, 5-bit register addresses.

Ports:
- `clk`  in  1  Clock; all state updates on the rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `inValid`  in  1  An operation is presented on `op`, `rs1`, `rs2` and `rd`.
- `inReady`  out  1  Sequencer can accept an operation.
- `op`  in  3  Operation code.
- `rs1`, `rs2`, `rd`  in  5 each  Source and destination register numbers.
- `sr1`, `sr2`  out  5 each  Read addresses to the regbank.
- `rdData1`, `rdData2`  in  32 each  Combinational read data from the regbank.
- `dr`  out  5  Write address to the regbank.
- `write`  out  1  Write enable to the regbank.
- `wrData`  out  32  Write data to the regbank.
- `done`  out  1  One-cycle pulse on write-back.
- `result`  out  32  Last computed result; held until the next write-back.
- `zero`, `carry`  out  1 each  Flags of the last result; held with `result`.

## Operation
- FSM states: IDLE → READ → EXEC → WB → IDLE. No other transitions occur except reset.
- IDLE:
  - `inReady`=1.
  - If `inValid`=1, latch `op`, `rs1`, `rs2` and `rd`, then go to READ.
  - The handshake completes only on a cycle where both `inValid` and `inReady` are 1.
- READ:
  - `sr1`=latched `rs1`, `sr2`=latched `rs2`.
  - Capture `rdData1` into A and `rdData2` into B at the end of the cycle.
- EXEC: compute from A and B, and register the outcome into `result`, `zero` and `carry`.
  - 000 ADD: A+B; `carry` = bit 32 of the 33-bit sum.
  - 001 SUB: A−B computed as A+~B+1; `carry` = bit 32 (1 means no borrow).
  - 010 AND, 011 OR, 100 XOR.
  - 101 SLT: result 1 if A<B (signed), else 0.
  - 110 SLL: A << B[4:0].
  - 111 MOV: result = A.
  - For all logical, SLT, SLL and MOV operations, `carry`=0.
  - `zero` = (result == 0). All arithmetic wraps modulo 2^32.
- WB:
  - `write`=1, `dr`=latched `rd`, `wrData`=`result`, `done`=1. This lasts exactly one cycle.
  - Go to IDLE.
- Outside WB, `write`=0 and `done`=0. `sr1`, `sr2` and `dr` hold their last values.
- Reset:
  - State goes to IDLE.
  - `sr1`, `sr2`, `dr`, `wrData`, `result`, `zero`, `carry`, `write` and `done` all become 0.
  - `inReady` is 0 while `reset`=1.
  - Reset during READ, EXEC or WB discards the operation; no write occurs on or after the reset edge.
- `inValid` while `inReady`=0 is ignored. The source holds its fields until accepted.

## Timing
- Handshake at cycle T. READ is T+1, EXEC is T+2, WB is T+3 (`write` and `done` high), IDLE is T+4.
- The regbank register is updated at the edge ending T+3.
- Throughput: one operation per 4 cycles. The earliest next accept is T+4.
- Read-after-write:
  - The next operation's READ is no earlier than T+5, so it always sees the written value.
  - No bypass is required.
- `rs1`==`rs2`, and `rd` equal to either source, are legal and behave normally.
- `inReady` is combinational from state. It is high in the first cycle after reset deasserts.

## Configuration
- `REGBANK_ZERO_REG_EN` defined: register 0 is hardwired zero.
  - In READ, a source equal to 0 captures 0 regardless of `rdData1`/`rdData2`.
  - In WB with `rd`==0: `write` stays 0, but `done` pulses and `result`, `zero` and `carry` update normally.
- Undefined: register 0 is an ordinary register; reads and writes pass through unchanged.

## Test plan
- Reset, then idle: `inReady`=1, all other outputs 0. Assert reset during EXEC → no `write` pulse, state IDLE, `result`=0.
- Preload r1=0xFFFFFFFF, r2=1. ADD rd=3 → at T+3, `write`=1, `dr`=3, `wrData`=0, `zero`=1, `carry`=1, `done`=1.
- r1=5, r2=7:
  - SUB → 0xFFFFFFFE with `carry`=0.
  - SLT → 1.
  - SLL with r2=33 → 5<<1 = 10.
- Back-to-back: MOV r4←r1, then ADD r5=r4+r4 with `inValid` held high → second accept at T+4, r5=2×r1.
- Handshake hold: `inValid`=1 throughout a busy period → exactly one accept per 4 cycles, with no double accept.
- ZERO_REG variation (run with both builds):
  - With `REGBANK_ZERO_REG_EN`: MOV r0←r1 (r1=9) → `done`=1, `write`=0. Then ADD r6=r0+r1 → r6=9.
  - Without the macro: r0 is written to 9, and r6=18.

Source files
------------

// File: rtl/regbank_op_seq.sv
// Register-file client sequencer: accept op, read two sources, run ALU, write back.
// Optional REGBANK_ZERO_REG_EN makes register 0 read as zero and ignore writes.
module regbank_op_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        inValid,
    output logic        inReady,
    input  logic [2:0]  op,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    output logic [4:0]  sr1,
    output logic [4:0]  sr2,
    input  logic [31:0] rdData1,
    input  logic [31:0] rdData2,
    output logic [4:0]  dr,
    output logic        write,
    output logic [31:0] wrData,
    output logic        done,
    output logic [31:0] result,
    output logic        zero,
    output logic        carry
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic [2:0]  op_q;
    logic [4:0]  rd_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] alu_res;
    logic        alu_carry;
    logic [32:0] sum;
    logic [32:0] diff;
    logic        wb_write_en;

    assign accept = inValid & inReady;
    assign wrData = result;

`ifdef REGBANK_ZERO_REG_EN
    assign a_in        = (sr1 == 5'd0) ? 32'd0 : rdData1;
    assign b_in        = (sr2 == 5'd0) ? 32'd0 : rdData2;
    assign wb_write_en = (rd_q != 5'd0);
`else
    assign a_in        = rdData1;
    assign b_in        = rdData2;
    assign wb_write_en = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = READ;
            READ:    state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Gating with reset keeps a reset in WB from writing on the reset edge.
    always_comb begin
        inReady = 1'b0;
        write   = 1'b0;
        done    = 1'b0;
        if (!reset) begin
            inReady = (state == IDLE);
            done    = (state == WB);
            write   = (state == WB) && wb_write_en;
        end
    end

    always_comb begin
        sum       = {1'b0, a_q} + {1'b0, b_q};
        diff      = {1'b0, a_q} + {1'b0, ~b_q} + 33'd1;
        alu_res   = a_q;
        alu_carry = 1'b0;
        unique case (op_q)
            3'b000: begin alu_res = sum[31:0];  alu_carry = sum[32];  end
            3'b001: begin alu_res = diff[31:0]; alu_carry = diff[32]; end
            3'b010: alu_res = a_q & b_q;
            3'b011: alu_res = a_q | b_q;
            3'b100: alu_res = a_q ^ b_q;
            3'b101: alu_res = {31'd0, ($signed(a_q) < $signed(b_q))};
            3'b110: alu_res = a_q << b_q[4:0];
            default: alu_res = a_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= 3'd0;
            rd_q   <= 5'd0;
            sr1    <= 5'd0;
            sr2    <= 5'd0;
            dr     <= 5'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            result <= 32'd0;
            zero   <= 1'b0;
            carry  <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= op;
                rd_q <= rd;
                sr1  <= rs1;
                sr2  <= rs2;
            end
            if (state == READ) begin
                a_q <= a_in;
                b_q <= b_in;
            end
            if (state == EXEC) begin
                result <= alu_res;
                zero   <= (alu_res == 32'd0);
                carry  <= alu_carry;
                dr     <= rd_q;
            end
        end
    end

endmodule
